// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART: TX FIFO feeding a serialiser, single-register RX with sticky overrun.
// 16-byte register window at BASE_ADDR; one-cycle ready pulse per accepted strobe.
module uart_peripheral #(
  parameter logic [31:0] BASE_ADDR   = 32'h0003_0000,
  parameter int unsigned TX_DEPTH    = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        active,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int unsigned AW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [15:0] div;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        overrun;

  // ---------------- bus decode ----------------
  logic [1:0] offset;
  logic       hit, do_write, do_read, data_read;
  logic       push, pop;
  logic       tx_empty;
  logic [31:0] read_value;

  assign active    = addr[31:4] == BASE_ADDR[31:4];
  assign offset    = addr[3:2];
  assign hit       = active & (wen | ren);
  assign do_write  = active & wen & wmask[0];
  assign do_read   = active & ren & ~wen;
  assign data_read = do_read && (offset == 2'd0);

  logic unused_bits;
  assign unused_bits = &{1'b0, addr[1:0], wmask[3:1], wdata[31:16]};

  // ---------------- TX FIFO ----------------
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic [7:0]  fifo_head;

  assign fifo_empty = wr_ptr == rd_ptr;
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push       = do_write && (offset == 2'd0) && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- TX serialiser ----------------
  state_t      tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_idx, tx_idx_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_line, tx_line_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  // Every bit reloads the counter from div, so a divisor write lands on a bit boundary.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    pop        = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_line_n = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shift_n = fifo_head;
          tx_cnt_n   = div;
          tx_state_n = S_START;
          tx_line_n  = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt == '0) begin
          tx_state_n = S_DATA;
          tx_cnt_n   = div;
          tx_idx_n   = '0;
          tx_line_n  = tx_shift[0];
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_n = div;
          if (tx_idx == 3'd7) begin
            tx_state_n = S_STOP;
            tx_line_n  = 1'b1;
          end else begin
            tx_idx_n   = tx_idx + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_line_n  = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt == '0) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            tx_shift_n = fifo_head;
            tx_cnt_n   = div;
            tx_state_n = S_START;
            tx_line_n  = 1'b0;
          end else begin
            tx_state_n = S_IDLE;
            tx_line_n  = 1'b1;
          end
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  assign uart_tx  = tx_line;
  assign tx_empty = fifo_empty && (tx_state == S_IDLE);

  // ---------------- RX deserialiser ----------------
  logic        rx_meta, rx_sync, rx_prev;
  state_t      rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_idx, rx_idx_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_load;
  logic [16:0] div_inc;
  logic [15:0] half_bit;

  assign div_inc  = {1'b0, div} + 17'd1;
  assign half_bit = div_inc[16:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_load    = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_n = S_START;
          rx_cnt_n   = half_bit;
        end
      end
      S_START: begin
        if (rx_cnt <= 16'd1) begin
          if (rx_sync) begin
            rx_state_n = S_IDLE;
          end else begin
            rx_state_n = S_DATA;
            rx_cnt_n   = div;
            rx_idx_n   = '0;
          end
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          rx_cnt_n   = div;
          if (rx_idx == 3'd7) rx_state_n = S_STOP;
          else                rx_idx_n   = rx_idx + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt == '0) begin
          rx_state_n = S_IDLE;
          rx_load    = rx_sync;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  // ---------------- registers and read path ----------------
  always_comb begin
    read_value = '0;
    case (offset)
      2'd0:    read_value = {24'b0, rx_byte};
      2'd1:    read_value = {28'b0, overrun, rx_valid, tx_empty, fifo_full};
      2'd2:    read_value = {16'b0, div};
      default: read_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata    <= '0;
      ready    <= 1'b0;
      div      <= DEFAULT_DIV;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      ready <= hit;
      if (hit) rdata <= wen ? '0 : read_value;
      if (do_write && (offset == 2'd2)) div <= wdata[15:0];
      if (do_write && (offset == 2'd1) && wdata[3]) overrun <= 1'b0;
      // A completing frame beats a same-cycle DATA read: the new byte stays valid.
      if (rx_load) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
        if (rx_valid && !data_read) overrun <= 1'b1;
      end else if (data_read) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_peripheral.sv
// Bench for uart_peripheral: register-access vector table, directed and randomized
// TX/RX traffic checked against a frame-level model of the serial line.
module tb_uart_peripheral;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wmask;
  logic        wen, ren, ready, active, uart_tx, uart_rx;

  always #5 clk = ~clk;

  uart_peripheral #(
    .BASE_ADDR  (32'h0003_0000),
    .TX_DEPTH   (8),
    .DEFAULT_DIV(16'd103)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wdata  (wdata),
    .wmask  (wmask),
    .wen    (wen),
    .ren    (ren),
    .rdata  (rdata),
    .ready  (ready),
    .active (active),
    .uart_tx(uart_tx),
    .uart_rx(uart_rx)
  );

  localparam logic [31:0] A_DATA = 32'h0003_0000;
  localparam logic [31:0] A_STAT = 32'h0003_0004;
  localparam logic [31:0] A_DIV  = 32'h0003_0008;
  localparam logic [31:0] A_RSV  = 32'h0003_000C;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  m;
    logic        exp_rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(logic w, logic r, logic [31:0] a, logic [31:0] wd,
                              logic [3:0] m, logic er, logic cr, logic [31:0] ed);
    vec_t v;
    v.w = w; v.r = r; v.a = a; v.wd = wd; v.m = m;
    v.exp_rdy = er; v.chk_rd = cr; v.exp_rd = ed;
    return v;
  endfunction

  // Called at a negedge; returns at the next negedge with the response sampled.
  task automatic bus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] m, output logic act_s, output logic rdy,
                     output logic [31:0] rd);
    addr = a; wdata = wd; wmask = m; wen = w; ren = r;
    #1 act_s = active;
    @(negedge clk);
    rdy = ready; rd = rdata;
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [31:0] wd);
    logic act_s, rdy;
    logic [31:0] rd;
    bus(1'b1, 1'b0, a, wd, 4'hF, act_s, rdy, rd);
  endtask

  task automatic reg_read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic act_s, rdy;
    logic [31:0] rd;
    bus(1'b0, 1'b1, a, 32'h0, 4'h0, act_s, rdy, rd);
    check(name, rd, exp);
  endtask

  task automatic burst(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      addr = A_DATA; wdata = {24'h0, bytes[i]}; wmask = 4'hF; wen = 1'b1;
      @(negedge clk);
    end
    wen = 1'b0;
  endtask

  // Expected serial line: frames of start 0, eight data bits LSB first, stop 1,
  // each bit div+1 clocks, frames contiguous.
  task automatic tx_expect(input logic [7:0] bytes[$], input int div);
    int t = 0;
    logic [9:0] exp_frame, got;
    logic glitch, first;
    while (uart_tx !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (uart_tx !== 1'b0) begin
      check("tx_start_timeout", {31'h0, uart_tx}, 32'h0);
      return;
    end
    foreach (bytes[k]) begin
      exp_frame = {1'b1, bytes[k], 1'b0};
      got = '0;
      glitch = 1'b0;
      for (int b = 0; b < 10; b++) begin
        first = uart_tx;
        for (int c = 0; c <= div; c++) begin
          if (uart_tx !== first) glitch = 1'b1;
          @(negedge clk);
        end
        got[b] = first;
      end
      check($sformatf("tx_frame%0d", k), {21'h0, glitch, got}, {21'h0, 1'b0, exp_frame});
    end
  endtask

  task automatic idle_check(input string name, input int cycles);
    logic bad = 1'b0;
    repeat (cycles) begin
      if (uart_tx !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    check(name, {31'h0, bad}, 32'h0);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (div + 1) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic act_s, rdy, exp_act;
    logic [31:0] rd;
    logic [7:0] q[$];
    logic [7:0] b1, b2, b;
    logic stop_ok;
    int dv, n;
    logic mdl_valid, mdl_ovr;
    logic [7:0] mdl_byte;

    rst = 1'b1; addr = '0; wdata = '0; wmask = '0; wen = 1'b0; ren = 1'b0; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("reset_ready",   {31'h0, ready},   32'h0);
    check("reset_rdata",   rdata,            32'h0);

    vecs.push_back(mk(0, 1, A_STAT,       32'h0,        4'h0, 1, 1, 32'h2));
    vecs.push_back(mk(0, 1, A_DIV,        32'h0,        4'h0, 1, 1, 32'd103));
    vecs.push_back(mk(0, 1, A_RSV,        32'h0,        4'h0, 1, 1, 32'h0));
    vecs.push_back(mk(1, 0, A_RSV,        32'hFFFF_FFFF,4'hF, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, A_RSV,        32'h0,        4'h0, 1, 1, 32'h0));
    vecs.push_back(mk(1, 0, A_DIV,        32'h5,        4'h0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, A_DIV,        32'h0,        4'h0, 1, 1, 32'd103));
    vecs.push_back(mk(1, 0, A_DIV,        32'h1234,     4'h1, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, A_DIV,        32'h0,        4'h0, 1, 1, 32'h1234));
    vecs.push_back(mk(0, 1, 32'h0004_0008,32'h0,        4'h0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0004_0008,32'h9,        4'hF, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0002_0000,32'h55,       4'hF, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, A_DIV,        32'h0,        4'h0, 1, 1, 32'h1234));
    vecs.push_back(mk(0, 1, A_DATA,       32'h0,        4'h0, 1, 1, 32'h0));
    vecs.push_back(mk(1, 0, A_STAT,       32'h8,        4'hF, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, A_STAT,       32'h0,        4'h0, 1, 1, 32'h2));
    vecs.push_back(mk(1, 1, A_DIV,        32'h3,        4'h1, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, A_DIV,        32'h0,        4'h0, 1, 1, 32'h3));

    foreach (vecs[i]) begin
      bus(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].wd, vecs[i].m, act_s, rdy, rd);
      exp_act = (vecs[i].a[31:4] == 28'h0003000);
      check($sformatf("vec%0d_active", i), {31'h0, act_s}, {31'h0, exp_act});
      check($sformatf("vec%0d_ready", i), {31'h0, rdy}, {31'h0, vecs[i].exp_rdy});
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      @(negedge clk);
      check($sformatf("vec%0d_ready_drop", i), {31'h0, ready}, 32'h0);
    end
    check("idle_after_table", {31'h0, uart_tx}, 32'h1);

    // Directed 0xA5 at div=3.
    q = '{8'hA5};
    fork
      burst(q);
      tx_expect(q, 3);
    join
    idle_check("tx_a5_idle", 8);
    reg_read_check("tx_a5_status", A_STAT, 32'h2);

    // Ten back-to-back writes at div=3: byte 0 leaves the FIFO one cycle after it
    // lands and no frame ends during the burst, so bytes 1..8 fill it and byte 9 is dropped.
    q = {};
    for (int i = 0; i < 10; i++) q.push_back(8'($urandom));
    fork
      begin
        burst(q);
        reg_read_check("burst_status_full", A_STAT, 32'h1);
      end
      tx_expect(q[0:8], 3);
    join
    idle_check("burst_no_tenth", 100);
    reg_read_check("burst_status_end", A_STAT, 32'h2);

    for (int r = 0; r < 4; r++) begin
      dv = $urandom_range(0, 4);
      reg_write(A_DIV, dv);
      n = $urandom_range(1, 8);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      fork
        burst(q);
        tx_expect(q, dv);
      join
      idle_check($sformatf("rand_tx%0d_idle", r), 2 * (dv + 1));
      reg_read_check($sformatf("rand_tx%0d_status", r), A_STAT, 32'h2);
    end

    // RX directed 0x3C at div=7.
    reg_write(A_DIV, 32'd7);
    rx_send(8'h3C, 1'b1, 7);
    repeat (3) @(negedge clk);
    reg_read_check("rx_status_valid", A_STAT, 32'h6);
    reg_read_check("rx_data", A_DATA, 32'h3C);
    reg_read_check("rx_status_cleared", A_STAT, 32'h2);

    // Overrun: two good frames with no read in between.
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    rx_send(b1, 1'b1, 7);
    rx_send(b2, 1'b1, 7);
    repeat (3) @(negedge clk);
    reg_read_check("ovr_status", A_STAT, 32'hE);
    reg_read_check("ovr_data", A_DATA, {24'h0, b2});
    reg_read_check("ovr_status_after_read", A_STAT, 32'hA);
    reg_write(A_STAT, 32'h8);
    reg_read_check("ovr_cleared", A_STAT, 32'h2);

    // Randomized RX frames against a register-level model.
    mdl_valid = 1'b0; mdl_ovr = 1'b0; mdl_byte = b2;
    for (int r = 0; r < 8; r++) begin
      dv = $urandom_range(2, 9);
      reg_write(A_DIV, dv);
      b = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      rx_send(b, stop_ok, dv);
      repeat (3) @(negedge clk);
      if (stop_ok) begin
        if (mdl_valid) mdl_ovr = 1'b1;
        mdl_valid = 1'b1;
        mdl_byte = b;
      end
      reg_read_check($sformatf("rand_rx%0d_status", r), A_STAT,
                     {28'h0, mdl_ovr, mdl_valid, 1'b1, 1'b0});
      if ($urandom_range(0, 1) == 1) begin
        reg_read_check($sformatf("rand_rx%0d_data", r), A_DATA, {24'h0, mdl_byte});
        mdl_valid = 1'b0;
      end
    end
    if (mdl_valid) begin
      reg_read_check("rand_rx_drain", A_DATA, {24'h0, mdl_byte});
      mdl_valid = 1'b0;
    end
    reg_write(A_STAT, 32'h8);
    reg_read_check("rand_rx_final_status", A_STAT, 32'h2);

    // Reset in the middle of a frame of zeros at div=7.
    reg_write(A_DIV, 32'd7);
    q = '{8'h00};
    burst(q);
    repeat (15) @(negedge clk);
    check("rst_mid_frame_low", {31'h0, uart_tx}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_tx_high", {31'h0, uart_tx}, 32'h1);
    rst = 1'b0;
    idle_check("rst_no_resume", 100);
    reg_read_check("rst_status", A_STAT, 32'h2);
    reg_read_check("rst_div", A_DIV, 32'd103);

    // One-clock RX glitch at the default divisor is a false start.
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (300) @(negedge clk);
    reg_read_check("glitch_status", A_STAT, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
